// File: rtl/seg_pkg.sv
// Shared constants, scan-state encoding and the per-digit display helper
// for the BCD counter / multiplexed 7-segment scan driver.
`timescale 1ns/1ps
package seg_pkg;
   localparam int         NUM_DIGITS = 4;
   localparam logic [3:0] BLANK_CODE = 4'hF;

   typedef enum logic [1:0] {
      DIG0 = 2'd0,
      DIG1 = 2'd1,
      DIG2 = 2'd2,
      DIG3 = 2'd3
   } scan_state_e;

   // Nibble to show for one digit position; a digit is blank only when it and every
   // digit above it are zero, so the ones digit is always shown.
   function automatic logic [3:0] digit_nibble(input logic [15:0] cnt,
                                               input scan_state_e st,
                                               input logic        blank_en);
      logic [3:0] nib;
      logic       upper_zero;
      nib        = cnt[3:0];
      upper_zero = 1'b0;
      case (st)
         DIG0: begin
            nib        = cnt[3:0];
            upper_zero = 1'b0;
         end
         DIG1: begin
            nib        = cnt[7:4];
            upper_zero = (cnt[15:4] == 12'd0);
         end
         DIG2: begin
            nib        = cnt[11:8];
            upper_zero = (cnt[15:8] == 8'd0);
         end
         DIG3: begin
            nib        = cnt[15:12];
            upper_zero = (cnt[15:12] == 4'd0);
         end
         default: begin
            nib        = cnt[3:0];
            upper_zero = 1'b0;
         end
      endcase
      return (blank_en && upper_zero) ? BLANK_CODE : nib;
   endfunction
endpackage

// File: rtl/bcd_digit.sv
// One decimal decade (0-9) with carry in/out; chained to build the BCD counter.
`timescale 1ns/1ps
module bcd_digit (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clr,
   input  logic       cin,
   output logic [3:0] q,
   output logic       cout
);
   logic [3:0] q_q, q_d;

   assign cout = cin && (q_q == 4'd9);
   assign q    = q_q;

   always_comb begin
      q_d = q_q;
      if (clr) begin
         q_d = 4'd0;
      end else if (cin) begin
         q_d = (q_q >= 4'd9) ? 4'd0 : q_q + 4'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) q_q <= 4'd0;
      else        q_q <= q_d;
   end
endmodule

// File: rtl/bcd_scan_driver.sv
// Four-decade BCD up-counter with a multiplexed digit scanner: a prescaler paces a
// DIG0..DIG3 ring, and the selected digit's nibble is registered alongside its select.
`timescale 1ns/1ps
module bcd_scan_driver
   import seg_pkg::*;
#(
   parameter int SCAN_DIV = 1000,
   parameter bit BLANK_LZ = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        inc,
   input  logic        clr,
   output logic [15:0] count,
   output logic [3:0]  digit_data,
   output logic [3:0]  digit_sel,
   output logic        ovf
);
   localparam int            PW         = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);

   logic [NUM_DIGITS:0] carry;
   logic [PW-1:0]       presc_q, presc_d;
   logic                ovf_q, ovf_d;
   logic                adv;
   scan_state_e         state_q, state_d;
   logic [3:0]          sel_q, sel_d;
   logic [3:0]          data_q, data_d;

   assign carry[0] = inc;

   for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
      bcd_digit u_digit (
         .clk  (clk),
         .rst_n(rst_n),
         .clr  (clr),
         .cin  (carry[g]),
         .q    (count[4*g +: 4]),
         .cout (carry[g+1])
      );
   end

   // Carry out of the top decade is the 9999 -> 0000 wrap; clear suppresses it.
   assign ovf_d   = carry[NUM_DIGITS] & ~clr;
   assign adv     = (presc_q == PRESC_LAST);
   assign presc_d = adv ? '0 : presc_q + 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= DIG0;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (adv) begin
         case (state_q)
            DIG0:    state_d = DIG1;
            DIG1:    state_d = DIG2;
            DIG2:    state_d = DIG3;
            DIG3:    state_d = DIG0;
            default: state_d = DIG0;
         endcase
      end
   end

   // Select and data both come from the upcoming state so they switch on the same edge.
   always_comb begin
      sel_d  = 4'b0001 << state_d;
      data_d = digit_nibble(count, state_d, BLANK_LZ);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_q <= '0;
         ovf_q   <= 1'b0;
         sel_q   <= 4'b0001;
         data_q  <= 4'h0;
      end else begin
         presc_q <= presc_d;
         ovf_q   <= ovf_d;
         sel_q   <= sel_d;
         data_q  <= data_d;
      end
   end

   assign ovf        = ovf_q;
   assign digit_sel  = sel_q;
   assign digit_data = data_q;
endmodule
